mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, a two-state data-memory access
// controller with a bounded wait, and the MEM/WB register feeding write-back.
module mem_stage (
  input  logic        clk,
  input  logic        rest,
  input  logic [15:0] Controll_Signals_In,
  input  logic [15:0] AluResult_In,
  input  logic [15:0] StoreData_In,
  input  logic [3:0]  Rd_In,
  input  logic        Flush_In,
  input  logic        Mem_Ack,
  input  logic [15:0] Mem_RData,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  output logic        Stall_Out,
  output logic [15:0] EXMEMData,
  output logic [3:0]  EXMEM_Rd,
  output logic        EXMEM_RegWrite,
  output logic [15:0] MEMWBData,
  output logic [3:0]  MEMWB_Rd,
  output logic        MEMWB_RegWrite,
  output logic        Mem_Err
);

  localparam int REG_WRITE_BIT  = 15;
  localparam int MEM_TO_REG_BIT = 13;
  localparam int MEM_READ_BIT   = 12;
  localparam int MEM_WRITE_BIT  = 11;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        mem_err_q;

  logic        exmem_reg_write;
  logic        exmem_mem_to_reg;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic [15:0] exmem_alu;
  logic [15:0] exmem_store;
  logic [3:0]  exmem_rd;

  logic        in_access;
  logic        held_write;
  logic        held_read;
  logic        timeout;
  logic        incoming_mem;
  logic [15:0] wb_data;
  logic        wb_reg_write;
  logic        unused_ctrl;

  // Control bits the stage never looks at are folded into a sink signal.
  assign unused_ctrl = ^{Controll_Signals_In[14], Controll_Signals_In[10:0]};

  // A write wins when both MemRead and MemWrite are set.
  assign in_access    = (state == ACCESS);
  assign held_write   = exmem_mem_write;
  assign held_read    = exmem_mem_read & ~exmem_mem_write;
  assign timeout      = in_access & ~Mem_Ack & (wait_cnt == 4'hF);
  assign Stall_Out    = in_access & ~Mem_Ack & ~timeout;
  assign incoming_mem = ~Flush_In &
                        (Controll_Signals_In[MEM_READ_BIT] | Controll_Signals_In[MEM_WRITE_BIT]);

  assign Mem_Req   = in_access;
  assign Mem_We    = in_access & held_write;
  assign Mem_Addr  = in_access ? exmem_alu   : 16'h0000;
  assign Mem_WData = in_access ? exmem_store : 16'h0000;

  // A held load cannot forward a value yet, so its RegWrite is hidden.
  assign EXMEMData      = exmem_alu;
  assign EXMEM_Rd       = exmem_rd;
  assign EXMEM_RegWrite = exmem_reg_write & ~held_read;

  // The error flag is visible in the very cycle the timeout happens.
  assign Mem_Err = mem_err_q | timeout;

  // EX/MEM register: loads whenever the stage is not stalled, bubble on flush.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_alu        <= 16'h0000;
      exmem_store      <= 16'h0000;
      exmem_rd         <= 4'h0;
    end else if (!Stall_Out) begin
      if (Flush_In) begin
        exmem_reg_write  <= 1'b0;
        exmem_mem_to_reg <= 1'b0;
        exmem_mem_read   <= 1'b0;
        exmem_mem_write  <= 1'b0;
        exmem_alu        <= 16'h0000;
        exmem_store      <= 16'h0000;
        exmem_rd         <= 4'h0;
      end else begin
        exmem_reg_write  <= Controll_Signals_In[REG_WRITE_BIT];
        exmem_mem_to_reg <= Controll_Signals_In[MEM_TO_REG_BIT];
        exmem_mem_read   <= Controll_Signals_In[MEM_READ_BIT];
        exmem_mem_write  <= Controll_Signals_In[MEM_WRITE_BIT];
        exmem_alu        <= AluResult_In;
        exmem_store      <= StoreData_In;
        exmem_rd         <= Rd_In;
      end
    end
  end

  // Access controller: stays in ACCESS while waiting, re-enters it directly
  // when a new memory op is loaded on the completing edge.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state    <= IDLE;
      wait_cnt <= 4'h0;
    end else if (Stall_Out) begin
      wait_cnt <= wait_cnt + 4'h1;
    end else if (incoming_mem) begin
      state    <= ACCESS;
      wait_cnt <= 4'h0;
    end else begin
      state    <= IDLE;
      wait_cnt <= 4'h0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      mem_err_q <= 1'b0;
    end else if (timeout) begin
      mem_err_q <= 1'b1;
    end
  end

  // Write-back value: memory data for loads to register, zeroed on timeout.
  always_comb begin
    wb_data      = exmem_alu;
    wb_reg_write = exmem_reg_write & ~held_write;
    if (held_read && exmem_mem_to_reg) begin
      wb_data = Mem_RData;
    end
    if (timeout) begin
      wb_data      = 16'h0000;
      wb_reg_write = 1'b0;
    end
  end

  // MEM/WB register: takes the completed instruction, or a bubble while stalled.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      MEMWBData      <= 16'h0000;
      MEMWB_Rd       <= 4'h0;
      MEMWB_RegWrite <= 1'b0;
    end else if (Stall_Out) begin
      MEMWBData      <= 16'h0000;
      MEMWB_Rd       <= 4'h0;
      MEMWB_RegWrite <= 1'b0;
    end else begin
      MEMWBData      <= wb_data;
      MEMWB_Rd       <= exmem_rd;
      MEMWB_RegWrite <= wb_reg_write;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard.
module tb_mem_stage;

  localparam logic [15:0] CTRL_NOP   = 16'h0000;
  localparam logic [15:0] CTRL_ALU   = 16'h8000;
  localparam logic [15:0] CTRL_LOAD  = 16'hB000;
  localparam logic [15:0] CTRL_STORE = 16'h8800;

  logic        clk;
  logic        rest;
  logic [15:0] Controll_Signals_In;
  logic [15:0] AluResult_In;
  logic [15:0] StoreData_In;
  logic [3:0]  Rd_In;
  logic        Flush_In;
  logic        Mem_Ack;
  logic [15:0] Mem_RData;
  logic        Mem_Req;
  logic        Mem_We;
  logic [15:0] Mem_Addr;
  logic [15:0] Mem_WData;
  logic        Stall_Out;
  logic [15:0] EXMEMData;
  logic [3:0]  EXMEM_Rd;
  logic        EXMEM_RegWrite;
  logic [15:0] MEMWBData;
  logic [3:0]  MEMWB_Rd;
  logic        MEMWB_RegWrite;
  logic        Mem_Err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [19:0] sb[$];

  mem_stage dut (
    .clk(clk), .rest(rest),
    .Controll_Signals_In(Controll_Signals_In), .AluResult_In(AluResult_In),
    .StoreData_In(StoreData_In), .Rd_In(Rd_In), .Flush_In(Flush_In),
    .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Stall_Out(Stall_Out),
    .EXMEMData(EXMEMData), .EXMEM_Rd(EXMEM_Rd), .EXMEM_RegWrite(EXMEM_RegWrite),
    .MEMWBData(MEMWBData), .MEMWB_Rd(MEMWB_Rd), .MEMWB_RegWrite(MEMWB_RegWrite),
    .Mem_Err(Mem_Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a wedged run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] ctrl, input logic [15:0] alu,
                                input logic [15:0] st, input logic [3:0] rd,
                                input logic flush);
    Controll_Signals_In = ctrl;
    AluResult_In        = alu;
    StoreData_In        = st;
    Rd_In               = rd;
    Flush_In            = flush;
    #1;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write-back must match the next expected entry, in order.
  always @(negedge clk) begin
    logic [19:0] exp_wb;
    if (!rest && MEMWB_RegWrite) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wb_unexpected: got rd %0d data 0x%04h, expected no write-back",
                 MEMWB_Rd, MEMWBData);
      end else begin
        exp_wb = sb.pop_front();
        check_output("wb_rd", {12'h000, MEMWB_Rd}, {12'h000, exp_wb[19:16]});
        check_output("wb_data", MEMWBData, exp_wb[15:0]);
      end
    end
  end

  initial begin
    int stall_count;
    int guard;

    rest = 1'b1;
    Mem_Ack = 1'b0;
    Mem_RData = 16'h0000;
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);

    // Reset state
    run_cycle();
    run_cycle();
    check_output("rst_mem_req", {15'h0, Mem_Req}, 16'h0);
    check_output("rst_stall", {15'h0, Stall_Out}, 16'h0);
    check_output("rst_memwb_rw", {15'h0, MEMWB_RegWrite}, 16'h0);
    check_output("rst_mem_err", {15'h0, Mem_Err}, 16'h0);
    rest = 1'b0;

    // Plain ALU op flows through in two edges
    apply_stimulus(CTRL_ALU, 16'h1234, 16'h0000, 4'h3, 1'b0);
    sb.push_back({4'h3, 16'h1234});
    run_cycle();
    check_output("alu_exmem_data", EXMEMData, 16'h1234);
    check_output("alu_exmem_rd", {12'h0, EXMEM_Rd}, 16'h0003);
    check_output("alu_exmem_rw", {15'h0, EXMEM_RegWrite}, 16'h1);
    check_output("alu_stall", {15'h0, Stall_Out}, 16'h0);
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);
    run_cycle();
    check_output("alu_memwb_data", MEMWBData, 16'h1234);
    check_output("alu_memwb_rd", {12'h0, MEMWB_Rd}, 16'h0003);
    check_output("alu_memwb_rw", {15'h0, MEMWB_RegWrite}, 16'h1);

    // Flush turns the incoming instruction into a bubble
    apply_stimulus(CTRL_ALU, 16'h7777, 16'h0000, 4'h8, 1'b1);
    run_cycle();
    check_output("flush_exmem_data", EXMEMData, 16'h0000);
    check_output("flush_exmem_rw", {15'h0, EXMEM_RegWrite}, 16'h0);
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);
    run_cycle();

    // Load with three wait cycles; flush asserted while stalled is ignored
    apply_stimulus(CTRL_LOAD, 16'h0040, 16'h0000, 4'h5, 1'b0);
    sb.push_back({4'h5, 16'hBEEF});
    run_cycle();
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b1);
    check_output("ld_mem_req", {15'h0, Mem_Req}, 16'h1);
    check_output("ld_mem_addr", Mem_Addr, 16'h0040);
    check_output("ld_mem_we", {15'h0, Mem_We}, 16'h0);
    check_output("ld_exmem_rw_hidden", {15'h0, EXMEM_RegWrite}, 16'h0);
    stall_count = 0;
    for (int i = 0; i < 3; i++) begin
      if (Stall_Out) stall_count++;
      run_cycle();
      check_output("ld_bubble", {15'h0, MEMWB_RegWrite}, 16'h0);
      check_output("ld_hold_addr", EXMEMData, 16'h0040);
    end
    Flush_In = 1'b0;
    Mem_Ack = 1'b1;
    Mem_RData = 16'hBEEF;
    #1;
    check_output("ld_ack_stall", {15'h0, Stall_Out}, 16'h0);
    run_cycle();
    Mem_Ack = 1'b0;
    #1;
    check_output("ld_stall_cycles", stall_count[15:0], 16'd3);
    check_output("ld_memwb_data", MEMWBData, 16'hBEEF);
    check_output("ld_req_drop", {15'h0, Mem_Req}, 16'h0);

    // Zero-wait store; RegWrite in the control word must not reach write-back
    apply_stimulus(CTRL_STORE, 16'h0010, 16'h00AA, 4'h7, 1'b0);
    run_cycle();
    Mem_Ack = 1'b1;
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);
    check_output("st_we", {15'h0, Mem_We}, 16'h1);
    check_output("st_wdata", Mem_WData, 16'h00AA);
    check_output("st_addr", Mem_Addr, 16'h0010);
    check_output("st_stall", {15'h0, Stall_Out}, 16'h0);
    run_cycle();
    Mem_Ack = 1'b0;
    #1;
    check_output("st_we_drop", {15'h0, Mem_We}, 16'h0);
    check_output("st_memwb_rw", {15'h0, MEMWB_RegWrite}, 16'h0);

    // Load that is never acknowledged times out
    Mem_RData = 16'hDEAD;
    apply_stimulus(CTRL_LOAD, 16'h0080, 16'h0000, 4'h9, 1'b0);
    run_cycle();
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);
    guard = 0;
    while (Stall_Out && guard < 40) begin
      guard++;
      run_cycle();
    end
    check_output("to_stall_cycles", guard[15:0], 16'd15);
    check_output("to_stall_released", {15'h0, Stall_Out}, 16'h0);
    check_output("to_err_now", {15'h0, Mem_Err}, 16'h1);
    run_cycle();
    check_output("to_memwb_data", MEMWBData, 16'h0000);
    check_output("to_memwb_rw", {15'h0, MEMWB_RegWrite}, 16'h0);
    check_output("to_req_drop", {15'h0, Mem_Req}, 16'h0);
    repeat (3) run_cycle();
    check_output("to_err_sticky", {15'h0, Mem_Err}, 16'h1);

    // Back-to-back loads, each acknowledged after one wait cycle
    apply_stimulus(CTRL_LOAD, 16'h0100, 16'h0000, 4'h1, 1'b0);
    sb.push_back({4'h1, 16'h1111});
    run_cycle();
    apply_stimulus(CTRL_LOAD, 16'h0102, 16'h0000, 4'h2, 1'b0);
    check_output("b2b_a_stall", {15'h0, Stall_Out}, 16'h1);
    run_cycle();
    Mem_Ack = 1'b1;
    Mem_RData = 16'h1111;
    #1;
    check_output("b2b_a_nostall", {15'h0, Stall_Out}, 16'h0);
    check_output("b2b_a_addr", Mem_Addr, 16'h0100);
    sb.push_back({4'h2, 16'h2222});
    run_cycle();
    Mem_Ack = 1'b0;
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);
    check_output("b2b_req_held", {15'h0, Mem_Req}, 16'h1);
    check_output("b2b_b_addr", Mem_Addr, 16'h0102);
    check_output("b2b_b_stall", {15'h0, Stall_Out}, 16'h1);
    check_output("b2b_a_data", MEMWBData, 16'h1111);
    run_cycle();
    Mem_Ack = 1'b1;
    Mem_RData = 16'h2222;
    #1;
    check_output("b2b_b_nostall", {15'h0, Stall_Out}, 16'h0);
    run_cycle();
    Mem_Ack = 1'b0;
    #1;
    check_output("b2b_b_data", MEMWBData, 16'h2222);
    check_output("b2b_req_drop", {15'h0, Mem_Req}, 16'h0);

    // Reset in the second wait cycle abandons the load
    apply_stimulus(CTRL_LOAD, 16'h0200, 16'h0000, 4'h4, 1'b0);
    run_cycle();
    apply_stimulus(CTRL_ALU, 16'h0055, 16'h0000, 4'h6, 1'b0);
    run_cycle();
    rest = 1'b1;
    #1;
    check_output("rr_req", {15'h0, Mem_Req}, 16'h0);
    check_output("rr_stall", {15'h0, Stall_Out}, 16'h0);
    check_output("rr_err", {15'h0, Mem_Err}, 16'h0);
    check_output("rr_exmem_data", EXMEMData, 16'h0000);
    check_output("rr_memwb_data", MEMWBData, 16'h0000);
    run_cycle();
    rest = 1'b0;
    sb.push_back({4'h6, 16'h0055});
    run_cycle();
    apply_stimulus(CTRL_NOP, 16'h0000, 16'h0000, 4'h0, 1'b0);
    check_output("rr_next_exmem", EXMEMData, 16'h0055);
    run_cycle();
    check_output("rr_next_memwb", MEMWBData, 16'h0055);

    repeat (3) run_cycle();
    check_output("sb_drained", sb.size(), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
